// File: rtl/arb_defs.sv
// Shared definitions for the bus_mux_arbiter slice: state encodings, owner IDs,
// the default hold limit and a saturating counter helper.
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  localparam logic OWN_A_ID = 1'b0;
  localparam logic OWN_B_ID = 1'b1;

  localparam int unsigned ARB_MAX_HOLD = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Clearable hold counter that saturates at MAX_HOLD-1 and flags when it sits at
// that limit.
module arb_hold_counter
  import arb_defs::*;
#(
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/bus_mux_arbiter.sv
// Two-requester round-robin arbiter owning the 2:1 data-bus mux select, with a
// bounded hold time and a registered data stage. Optional preempt_cnt output is
// enabled by defining ARB_PREEMPT_CNT_EN.
module bus_mux_arbiter
  import arb_defs::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_src
`ifdef ARB_PREEMPT_CNT_EN
  , output logic [7:0]     preempt_cnt
`endif
);

  arb_state_e       state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_owner_q, last_owner_d;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_src_q;
  logic             at_limit_s;
  logic             change_s;
  logic             own_req_s;

  // Next-state decision; a waiting peer at the hold limit forces rotation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_owner_q == OWN_A_ID) ? ST_OWN_B : ST_OWN_A;
        end else if (req_a) begin
          state_d = ST_OWN_A;
        end else if (req_b) begin
          state_d = ST_OWN_B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_A: begin
        if (!req_a) begin
          state_d = req_b ? ST_OWN_B : ST_IDLE;
        end else if (req_b && at_limit_s) begin
          state_d = ST_OWN_B;
        end else begin
          state_d = ST_OWN_A;
        end
      end
      ST_OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? ST_OWN_A : ST_IDLE;
        end else if (req_a && at_limit_s) begin
          state_d = ST_OWN_A;
        end else begin
          state_d = ST_OWN_B;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign change_s  = (state_d != state_q);
  assign own_req_s = ((state_q == ST_OWN_A) && req_a) || ((state_q == ST_OWN_B) && req_b);

  // Select and round-robin history follow the incoming owner; IDLE keeps both.
  always_comb begin
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    case (state_d)
      ST_OWN_A: begin
        sel_d        = OWN_A_ID;
        last_owner_d = OWN_A_ID;
      end
      ST_OWN_B: begin
        sel_d        = OWN_B_ID;
        last_owner_d = OWN_B_ID;
      end
      default: begin
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
      end
    endcase
  end

  arb_hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .clk        (clk),
    .n_reset    (n_reset),
    .clr_i      (change_s),
    .inc_i      ((state_q != ST_IDLE) && !change_s),
    .at_limit_o (at_limit_s)
  );

  // Control registers; A wins the first tie because history starts at B.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= OWN_A_ID;
      last_owner_q <= OWN_B_ID;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Data stage: only a still-requesting owner produces a transfer.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_data_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= own_req_s;
      if (own_req_s) begin
        out_data_q <= sel_q ? data_b : data_a;
        out_src_q  <= sel_q;
      end
    end
  end

`ifdef ARB_PREEMPT_CNT_EN
  logic [7:0] preempt_q;
  logic       forced_s;

  assign forced_s = req_a && req_b && at_limit_s &&
                    (((state_q == ST_OWN_A) && (state_d == ST_OWN_B)) ||
                     ((state_q == ST_OWN_B) && (state_d == ST_OWN_A)));

  // Forced-rotation counter, saturating.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      preempt_q <= 8'd0;
    end else if (forced_s) begin
      preempt_q <= sat_inc8(preempt_q);
    end
  end

  assign preempt_cnt = preempt_q;
`endif

  assign gnt_a     = (state_q == ST_OWN_A);
  assign gnt_b     = (state_q == ST_OWN_B);
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed self-checking bench for bus_mux_arbiter; preempt_cnt checks are
// included when ARB_PREEMPT_CNT_EN is defined.
module tb_bus_mux_arbiter;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       req_a, req_b;
  logic [3:0] data_a, data_b;
  logic       gnt_a, gnt_b, sel, out_valid, out_src;
  logic [3:0] out_data;
`ifdef ARB_PREEMPT_CNT_EN
  logic [7:0] preempt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req_a     (req_a),
    .req_b     (req_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_src   (out_src)
`ifdef ARB_PREEMPT_CNT_EN
    , .preempt_cnt (preempt_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    n_reset = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    step();
    step();
    n_reset = 1'b1;
  endtask

  initial begin
    n_reset = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    data_a  = 4'b0000;
    data_b  = 4'b0000;
    #2;
    chk("rst_gnt_a", {7'd0, gnt_a}, 8'd0);
    chk("rst_gnt_b", {7'd0, gnt_b}, 8'd0);
    chk("rst_sel", {7'd0, sel}, 8'd0);
    chk("rst_data", {4'd0, out_data}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_src", {7'd0, out_src}, 8'd0);
    step();
    step();
    n_reset = 1'b1;

    // Single requester A
    req_a  = 1'b1;
    data_a = 4'b1010;
    step();
    chk("a_gnt_a", {7'd0, gnt_a}, 8'd1);
    chk("a_gnt_b", {7'd0, gnt_b}, 8'd0);
    chk("a_sel", {7'd0, sel}, 8'd0);
    chk("a_valid_e1", {7'd0, out_valid}, 8'd0);
    step();
    chk("a_data_e2", {4'd0, out_data}, 8'b0000_1010);
    chk("a_valid_e2", {7'd0, out_valid}, 8'd1);
    chk("a_src_e2", {7'd0, out_src}, 8'd0);
    req_a = 1'b0;
    step();
    chk("a_rel_gnt", {7'd0, gnt_a}, 8'd0);
    chk("a_rel_valid", {7'd0, out_valid}, 8'd0);
    chk("a_rel_hold", {4'd0, out_data}, 8'b0000_1010);
    step();
    chk("a_idle_valid", {7'd0, out_valid}, 8'd0);

    // Tie from reset: A first, forced rotation after 4 owned cycles
    apply_reset();
    req_a  = 1'b1;
    req_b  = 1'b1;
    data_a = 4'b0001;
    data_b = 4'b0101;
    step();
    chk("tie_first_a", {7'd0, gnt_a}, 8'd1);
    step();
    step();
    step();
    chk("tie_a_e4", {7'd0, gnt_a}, 8'd1);
    chk("tie_data_e4", {4'd0, out_data}, 8'b0000_0001);
    chk("tie_src_e4", {7'd0, out_src}, 8'd0);
    step();
    chk("tie_rot_gnt_b", {7'd0, gnt_b}, 8'd1);
    chk("tie_rot_gnt_a", {7'd0, gnt_a}, 8'd0);
    chk("tie_rot_sel", {7'd0, sel}, 8'd1);
    step();
    chk("tie_b_data", {4'd0, out_data}, 8'b0000_0101);
    chk("tie_b_src", {7'd0, out_src}, 8'd1);
    chk("tie_b_valid", {7'd0, out_valid}, 8'd1);
    step();
    step();
    chk("tie_b_e8", {7'd0, gnt_b}, 8'd1);
    step();
    chk("tie_back_a", {7'd0, gnt_a}, 8'd1);
    chk("tie_back_sel", {7'd0, sel}, 8'd0);
`ifdef ARB_PREEMPT_CNT_EN
    chk("tie_preempt", preempt_cnt, 8'd2);
`endif

    // Handover without an idle bubble
    req_a = 1'b0;
    step();
    chk("ho_gnt_b", {7'd0, gnt_b}, 8'd1);
    chk("ho_gnt_a", {7'd0, gnt_a}, 8'd0);
    chk("ho_gap", {7'd0, out_valid}, 8'd0);
    step();
    chk("ho_valid", {7'd0, out_valid}, 8'd1);
    chk("ho_data", {4'd0, out_data}, 8'b0000_0101);
    chk("ho_src", {7'd0, out_src}, 8'd1);
    req_b = 1'b0;
    step();
    chk("ho_idle_gnt", {6'd0, gnt_a, gnt_b}, 8'd0);
    chk("ho_idle_valid", {7'd0, out_valid}, 8'd0);

    // One-cycle pulse on B
    req_b = 1'b1;
    step();
    chk("pulse_gnt_b", {7'd0, gnt_b}, 8'd1);
    req_b = 1'b0;
    step();
    chk("pulse_idle", {6'd0, gnt_a, gnt_b}, 8'd0);
    chk("pulse_valid", {7'd0, out_valid}, 8'd0);
    chk("pulse_sel_hold", {7'd0, sel}, 8'd1);
    step();
    chk("pulse_valid2", {7'd0, out_valid}, 8'd0);

    // Saturated hold: a late request from B rotates on the very next edge
    req_a  = 1'b1;
    data_a = 4'b0011;
    repeat (6) step();
    chk("sat_gnt_a", {7'd0, gnt_a}, 8'd1);
    chk("sat_data", {4'd0, out_data}, 8'b0000_0011);
    req_b = 1'b1;
    step();
    chk("sat_rot_b", {7'd0, gnt_b}, 8'd1);
`ifdef ARB_PREEMPT_CNT_EN
    chk("sat_preempt", preempt_cnt, 8'd3);
`endif
    req_a = 1'b0;
    req_b = 1'b0;

    // Reset mid-grant clears outputs before the next edge
    apply_reset();
    req_b  = 1'b1;
    data_b = 4'b0110;
    step();
    chk("mid_gnt_b", {7'd0, gnt_b}, 8'd1);
    step();
    chk("mid_valid", {7'd0, out_valid}, 8'd1);
    chk("mid_data", {4'd0, out_data}, 8'b0000_0110);
    #2;
    n_reset = 1'b0;
    #1;
    chk("mid_rst_gnt", {6'd0, gnt_a, gnt_b}, 8'd0);
    chk("mid_rst_sel", {7'd0, sel}, 8'd0);
    chk("mid_rst_data", {4'd0, out_data}, 8'd0);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_src", {7'd0, out_src}, 8'd0);
    req_b = 1'b0;

`ifdef ARB_PREEMPT_CNT_EN
    chk("pc_reset", preempt_cnt, 8'd0);
    n_reset = 1'b1;
    req_a   = 1'b1;
    req_b   = 1'b1;
    repeat (20) step();
    chk("pc_20", preempt_cnt, 8'd4);
    repeat (1100) step();
    chk("pc_sat", preempt_cnt, 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
